netlist_sig_checker: RTL and testbench

- Downstream consumer of the synthesized design's 8-bit `out_signal` bus, used in gate-level and RTL verification benches.
- Waits a programmable number of post-start cycles, then compresses a fixed number of samples into a MISR signature.
- Compares the final signature against an expected value and reports pass/fail, plus a stuck-bus flag.
- Lets netlist runs self-check instead of relying on VCD inspection.

---
 rtl/netlist_sig_checker.sv | 135 +++++++++++++
 tb/tb_netlist_sig_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/netlist_sig_checker.sv
// Compresses a window of samples from a monitored bus into a MISR signature and grades it.
// Latency: done rises SKIP_CYCLES + NUM_SAMPLES edges after the start edge.
// Backpressure: none; start while busy is ignored, start while done restarts the run.
module netlist_sig_checker #(
   parameter int                DATA_W      = 8,
   parameter int                NUM_SAMPLES = 10,
   parameter int                SKIP_CYCLES = 2,
   parameter logic [DATA_W-1:0] MISR_POLY   = 8'h1D,
   parameter logic [DATA_W-1:0] MISR_SEED   = 8'hFF,
   localparam int               CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [DATA_W-1:0] expected_sig,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [DATA_W-1:0] signature,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic              stuck_flag
);

   // Skip counter only has to reach SKIP_CYCLES-1; keep at least one bit so the
   // declaration stays legal when the skip window is empty.
   localparam int SKW = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SKW-1:0]    skip_cnt;
   logic [DATA_W-1:0] prev_sample;
   logic              changed;

   logic              launch;
   logic              capture;
   logic              last;
   logic              skip_last;
   logic              cap_last;
   logic              diff;
   logic [DATA_W-1:0] misr_next;

   assign skip_last = (int'(skip_cnt) == SKIP_CYCLES - 1);
   assign cap_last  = (int'(sample_cnt) == NUM_SAMPLES - 1);

   // A transition is only meaningful once a previous capture exists in this run.
   assign diff = (sample_cnt != '0) && (sample_in != prev_sample);

   // One MISR step: shift, fold the MSB back through the taps, xor in the sample.
   assign misr_next = {signature[DATA_W-2:0], 1'b0}
                    ^ (signature[DATA_W-1] ? MISR_POLY : '0)
                    ^ sample_in;

   assign busy = (state == SKIP) || (state == CAPTURE);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the per-edge action strobes for the datapath.
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      capture   = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch    = 1'b1;
               state_nxt = (SKIP_CYCLES == 0) ? CAPTURE : SKIP;
            end
         end
         SKIP: begin
            if (skip_last) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            capture = 1'b1;
            if (cap_last) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Signature, counters and verdict registers; everything holds outside a run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         signature   <= MISR_SEED;
         sample_cnt  <= '0;
         pass        <= 1'b0;
         stuck_flag  <= 1'b0;
         skip_cnt    <= '0;
         prev_sample <= '0;
         changed     <= 1'b0;
      end else if (launch) begin
         signature   <= MISR_SEED;
         sample_cnt  <= '0;
         pass        <= 1'b0;
         stuck_flag  <= 1'b0;
         skip_cnt    <= '0;
         changed     <= 1'b0;
      end else if (state == SKIP) begin
         skip_cnt <= skip_cnt + SKW'(1);
      end else if (capture) begin
         signature   <= misr_next;
         sample_cnt  <= sample_cnt + CNT_W'(1);
         prev_sample <= sample_in;
         if (diff) begin
            changed <= 1'b1;
         end
         if (last) begin
            pass       <= (misr_next == expected_sig);
            stuck_flag <= !(changed || diff);
         end
      end
   end

endmodule

// File: tb/tb_netlist_sig_checker.sv
// Bench for netlist_sig_checker: three parameterisations driven with random and directed sample windows.
// Latency: expects done exactly SKIP_CYCLES + NUM_SAMPLES edges after the start edge.
// Backpressure: none; start pulses during a run must be ignored.
module tb_netlist_sig_checker;

   logic       clk;
   logic       rst;
   logic       start_i [3];
   logic [7:0] smp     [3];
   logic [7:0] exp_sig [3];
   logic       busy_o  [3];
   logic       done_o  [3];
   logic       pass_o  [3];
   logic       stuck_o [3];
   logic [7:0] sig_o   [3];
   logic [3:0] cnt0;
   logic [1:0] cnt1;
   logic [0:0] cnt2;

   int         S_P [3] = '{2, 0, 1};
   int         N_P [3] = '{10, 2, 1};

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] stim [$];

   netlist_sig_checker u_def (
      .clk(clk), .rst(rst), .start(start_i[0]), .sample_in(smp[0]), .expected_sig(exp_sig[0]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]),
      .sample_cnt(cnt0), .stuck_flag(stuck_o[0])
   );

   netlist_sig_checker #(.NUM_SAMPLES(2), .SKIP_CYCLES(0)) u_two (
      .clk(clk), .rst(rst), .start(start_i[1]), .sample_in(smp[1]), .expected_sig(exp_sig[1]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]),
      .sample_cnt(cnt1), .stuck_flag(stuck_o[1])
   );

   netlist_sig_checker #(.NUM_SAMPLES(1), .SKIP_CYCLES(1)) u_one (
      .clk(clk), .rst(rst), .start(start_i[2]), .sample_in(smp[2]), .expected_sig(exp_sig[2]),
      .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .signature(sig_o[2]),
      .sample_cnt(cnt2), .stuck_flag(stuck_o[2])
   );

   always #5 clk = ~clk;

   function automatic int cnt_of(input int i);
      case (i)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   // Signature as a GF(2) polynomial: multiply by x modulo x^8+x^4+x^3+x^2+1, then add the sample.
   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
      logic [8:0] p;
      p = {s, 1'b0};
      if (p[8]) p = p ^ 9'h11D;
      return p[7:0] ^ d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, expv);
      end
   endtask

   task automatic fill_rand(input int len);
      stim.delete();
      for (int k = 0; k < len; k++) stim.push_back(8'($urandom));
   endtask

   task automatic fill_const(input int len, input logic [7:0] v);
      stim.delete();
      for (int k = 0; k < len; k++) stim.push_back(v);
   endtask

   // One run on instance i using stim[e-1] as the sample before edge e.
   // bad_exp: -2 golden expected value, -1 corrupted golden, otherwise a literal expected value.
   task automatic run(input int i, input int restart_at, input int abort_at, input int bad_exp);
      logic [7:0] sig;
      logic [7:0] cap [$];
      logic [7:0] fin;
      int         s;
      int         n;
      bit         stuck_exp;
      s   = S_P[i];
      n   = N_P[i];
      sig = 8'hFF;
      start_i[i] = 1'b1;
      smp[i]     = 8'($urandom);
      exp_sig[i] = 8'($urandom);
      @(negedge clk);
      start_i[i] = 1'b0;
      chk("start_busy", busy_o[i], 1);
      chk("start_done", done_o[i], 0);
      chk("start_sig", sig_o[i], 8'hFF);
      chk("start_cnt", cnt_of(i), 0);
      fin = 8'h00;
      for (int e = 1; e <= s + n; e++) begin
         smp[i] = stim[e-1];
         if (e > s) begin
            sig = misr_step(sig, stim[e-1]);
            cap.push_back(stim[e-1]);
         end
         if (e == s + n) begin
            if (bad_exp == -2)      fin = sig;
            else if (bad_exp == -1) fin = sig ^ 8'h5A;
            else                    fin = 8'(bad_exp);
            exp_sig[i] = fin;
         end else begin
            exp_sig[i] = 8'($urandom);
         end
         start_i[i] = (e == restart_at);
         @(negedge clk);
         start_i[i] = 1'b0;
         if (e == abort_at) begin
            rst = 1'b0;
            #1;
            chk("abort_busy", busy_o[i], 0);
            chk("abort_sig", sig_o[i], 8'hFF);
            chk("abort_cnt", cnt_of(i), 0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_done", done_o[i], 0);
            chk("abort_idle", busy_o[i], 0);
            return;
         end
         chk("busy", busy_o[i], (e < s + n));
         chk("done", done_o[i], (e == s + n));
         chk("sig", sig_o[i], sig);
         chk("cnt", cnt_of(i), (e > s) ? e - s : 0);
      end
      stuck_exp = 1'b1;
      foreach (cap[k]) if (cap[k] != cap[0]) stuck_exp = 1'b0;
      chk("pass", pass_o[i], (fin == sig));
      chk("stuck", stuck_o[i], stuck_exp);
      smp[i]     = 8'($urandom);
      exp_sig[i] = 8'($urandom);
      @(negedge clk);
      chk("hold_done", done_o[i], 1);
      chk("hold_sig", sig_o[i], sig);
      chk("hold_pass", pass_o[i], (fin == sig));
      chk("hold_cnt", cnt_of(i), n);
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_i[i] = 1'b0;
         smp[i]     = 8'h00;
         exp_sig[i] = 8'h00;
      end

      // Reset held with random activity on the inputs.
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'($urandom);
            smp[i]     = 8'($urandom);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         chk("rst_busy", busy_o[i], 0);
         chk("rst_done", done_o[i], 0);
         chk("rst_pass", pass_o[i], 0);
         chk("rst_stuck", stuck_o[i], 0);
         chk("rst_cnt", cnt_of(i), 0);
         chk("rst_sig", sig_o[i], 8'hFF);
         start_i[i] = 1'b0;
      end
      rst = 1'b1;
      for (int c = 0; c < 5; c++) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("idle_busy", busy_o[i], 0);
         chk("idle_done", done_o[i], 0);
         chk("idle_sig", sig_o[i], 8'hFF);
         chk("idle_cnt", cnt_of(i), 0);
      end

      // Zero bus on the two-sample instance: E3 then DB, golden DB.
      fill_const(2, 8'h00);
      run(1, -1, -1, 8'hDB);
      chk("zero_sig_const", sig_o[1], 8'hDB);
      chk("zero_pass_const", pass_o[1], 1);
      chk("zero_stuck_const", stuck_o[1], 1);

      // 01 then 02 aliases to DB; expected 00 must fail, bus is not stuck.
      stim.delete();
      stim.push_back(8'h01);
      stim.push_back(8'h02);
      run(1, -1, -1, 8'h00);
      chk("alias_sig_const", sig_o[1], 8'hDB);
      chk("alias_pass_const", pass_o[1], 0);
      chk("alias_stuck_const", stuck_o[1], 0);

      // Skip window on defaults: AA during skip must not reach the signature.
      fill_const(12, 8'h00);
      stim[0] = 8'hAA;
      stim[1] = 8'hAA;
      run(0, -1, -1, -2);

      // Start pulses during SKIP and mid-CAPTURE are ignored.
      fill_rand(12);
      run(0, 1, -1, -2);
      fill_rand(12);
      run(0, 5, -1, -2);

      // Reset during CAPTURE, then a fresh run.
      fill_rand(12);
      run(0, -1, 6, -2);
      fill_rand(12);
      run(0, -1, -1, -2);

      // Single-sample instance: always stuck.
      fill_rand(2);
      run(2, -1, -1, -2);
      fill_rand(2);
      run(2, -1, -1, -1);

      // Random mix across instances and sample patterns.
      for (int it = 0; it < 24; it++) begin
         int i;
         int mode;
         i    = int'($urandom_range(0, 2));
         mode = int'($urandom_range(0, 2));
         if (mode == 0)      fill_rand(S_P[i] + N_P[i]);
         else if (mode == 1) fill_const(S_P[i] + N_P[i], 8'($urandom));
         else begin
            fill_const(S_P[i] + N_P[i], 8'h3C);
            stim[S_P[i] + N_P[i] - 1] = 8'h3D;
         end
         run(i, ($urandom_range(0, 3) == 0) ? S_P[i] + 1 : -1, -1,
             ($urandom_range(0, 1) == 0) ? -2 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
